// File: rtl/sram_ctl.sv
// sram_ctl: bridges the SPI slave's parallel strobes to timed accesses on an async 8-bit SRAM.
module sram_ctl #(
  parameter int ADDR_W      = 7,
  parameter int WAIT_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [6:0]        address_bus,
  inout  wire  [7:0]        data_bus,
  input  logic              read_n,
  input  logic              write_n,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [7:0]        sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy,
  output logic              bus_err
);
  localparam int WC = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CW = $clog2(WC + 1);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WR_SETUP   = 3'd1;
  localparam logic [2:0] WR_PULSE   = 3'd2;
  localparam logic [2:0] WR_RECOVER = 3'd3;
  localparam logic [2:0] RELEASE    = 3'd4;
  localparam logic [2:0] RD_SETUP   = 3'd5;
  localparam logic [2:0] RD_WAIT    = 3'd6;
  localparam logic [2:0] RD_HOLD    = 3'd7;
  logic [2:0]             state_q, state_d;
  logic [SYNC_STAGES-1:0] rd_sync_q, wr_sync_q;
  logic                   rd_prev_q, wr_prev_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic                   err_q, err_d;
  logic                   rd_s, wr_s, rd_rise, wr_rise, last;
  assign rd_s    = ~rd_sync_q[SYNC_STAGES-1];
  assign wr_s    = ~wr_sync_q[SYNC_STAGES-1];
  assign rd_rise = rd_s & ~rd_prev_q;
  assign wr_rise = wr_s & ~wr_prev_q;
  assign last    = cnt_q == CW'(WC - 1);
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    err_d     = err_q | (rd_s & wr_s);
    case (state_q)
      IDLE: begin
        // Edge-only starts: a strobe already low on return to IDLE never retriggers
        if (rd_rise | wr_rise) begin
          state_d = (rd_s & wr_s) ? RELEASE : (wr_rise ? WR_SETUP : RD_SETUP);
          addr_d  = (rd_s & wr_s) ? addr_q : ADDR_W'(address_bus);
          wdata_d = (wr_rise & ~rd_s) ? data_bus : wdata_q;
        end
      end
      WR_SETUP:   state_d = WR_PULSE;
      WR_PULSE:   state_d = last ? WR_RECOVER : WR_PULSE;
      WR_RECOVER: state_d = RELEASE;
      RELEASE:    state_d = (!rd_s && !wr_s) ? IDLE : RELEASE;
      RD_SETUP:   state_d = RD_WAIT;
      RD_WAIT: begin
        state_d   = last ? RD_HOLD : RD_WAIT;
        rd_data_d = last ? sram_data : rd_data_q;
      end
      default:    state_d = rd_s ? RD_HOLD : IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rd_sync_q <= '1;
      wr_sync_q <= '1;
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], read_n};
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], write_n};
      rd_prev_q <= rd_s;
      wr_prev_q <= wr_s;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end
  assign sram_addr = addr_q;
  assign sram_ce_n = !(state_q inside {WR_SETUP, WR_PULSE, WR_RECOVER, RD_SETUP, RD_WAIT});
  assign sram_oe_n = !(state_q inside {RD_SETUP, RD_WAIT});
  assign sram_we_n = state_q != WR_PULSE;
  assign busy      = state_q != IDLE;
  assign bus_err   = err_q;
  // Read data release follows raw read_n so the SPI side sees the bus freed without sync delay
  assign sram_data = (state_q inside {WR_SETUP, WR_PULSE, WR_RECOVER}) ? wdata_q : 8'bz;
  assign data_bus  = (state_q == RD_HOLD && !read_n) ? rd_data_q : 8'bz;
endmodule
